// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one Ethernet frame transmitter between NUM_REQ clients.
// Grants, latches the winner's frame fields, waits for completion or timeout, then holds off for the inter-frame gap.
module tx_frame_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [47:0]                src_addr,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [48*NUM_REQ-1:0]      req_dest_addr,
    input  logic [16*NUM_REQ-1:0]      req_eth_type,
    input  logic [32*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx_start,
    output logic [47:0]                tx_dest_addr,
    output logic [47:0]                tx_src_addr,
    output logic [15:0]                tx_eth_type,
    output logic [31:0]                tx_data,
    input  logic                       tx_done
);

    localparam int IW      = $clog2(NUM_REQ);
    localparam int MAX_CNT = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] IFG_LAST     = CW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_IFG} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [IW-1:0]      last_reg, grant_reg, winner;
    logic [NUM_REQ-1:0] ack_reg, ack_next, err_reg, err_next;
    logic               tx_start_reg, tx_start_next;
    logic               grant_en;
    logic [47:0]        dest_reg, src_reg;
    logic [15:0]        type_reg;
    logic [31:0]        data_reg;

    logic [47:0]        dest_arr [NUM_REQ];
    logic [15:0]        type_arr [NUM_REQ];
    logic [31:0]        data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;
    logic [IW:0]        rot_base;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign dest_arr[gi] = req_dest_addr[48*gi +: 48];
            assign type_arr[gi] = req_eth_type[16*gi +: 16];
            assign data_arr[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Rotate so bit 0 is the requester right after the last winner; lowest set bit wins.
    assign rot_base = {1'b0, last_reg} + (IW+1)'(1);
    assign req_rot  = NUM_REQ'({req, req} >> rot_base);

    always_comb begin
        winner = last_reg;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                winner = IW'((int'(last_reg) + 1 + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        err_next      = '0;
        tx_start_next = 1'b0;
        grant_en      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (|req) begin
                    grant_en      = 1'b1;
                    tx_start_next = 1'b1;
                    state_next    = S_START;
                end
            end
            S_START: begin
                cnt_next   = '0;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Completion takes priority over a timeout landing on the same cycle.
                if (tx_done) begin
                    ack_next[grant_reg] = 1'b1;
                    cnt_next            = '0;
                    state_next          = S_IFG;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    err_next[grant_reg] = 1'b1;
                    cnt_next            = '0;
                    state_next          = S_IFG;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_IFG: begin
                if (cnt_reg == IFG_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            last_reg     <= IW'(NUM_REQ - 1);
            grant_reg    <= '0;
            ack_reg      <= '0;
            err_reg      <= '0;
            tx_start_reg <= 1'b0;
            dest_reg     <= '0;
            src_reg      <= '0;
            type_reg     <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            tx_start_reg <= tx_start_next;
            if (grant_en) begin
                last_reg  <= winner;
                grant_reg <= winner;
                dest_reg  <= dest_arr[winner];
                src_reg   <= src_addr;
                type_reg  <= type_arr[winner];
                data_reg  <= data_arr[winner];
            end
        end
    end

    assign ack          = ack_reg;
    assign err          = err_reg;
    assign grant_id     = grant_reg;
    assign busy         = (state_reg != S_IDLE);
    assign tx_start     = tx_start_reg;
    assign tx_dest_addr = dest_reg;
    assign tx_src_addr  = src_reg;
    assign tx_eth_type  = type_reg;
    assign tx_data      = data_reg;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: a frame-level timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and transmitter.
module tb_tx_frame_scheduler;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int IFG = 12;
    localparam int TO  = 64;

    localparam int W_START = 0;
    localparam int W_ACK   = 1;
    localparam int W_ANY   = 2;
    localparam int W_IDLE  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [47:0]     src_addr = '0;
    logic [N-1:0]    req = '0;
    logic [48*N-1:0] req_dest_addr = '0;
    logic [16*N-1:0] req_eth_type = '0;
    logic [32*N-1:0] req_data = '0;
    logic            tx_done = 1'b0;
    logic [N-1:0]    ack, err;
    logic [IW-1:0]   grant_id;
    logic            busy, tx_start;
    logic [47:0]     tx_dest_addr, tx_src_addr;
    logic [15:0]     tx_eth_type;
    logic [31:0]     tx_data;

    always #5 clk = ~clk;

    tx_frame_scheduler #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .req(req),
        .req_dest_addr(req_dest_addr), .req_eth_type(req_eth_type), .req_data(req_data),
        .ack(ack), .err(err), .grant_id(grant_id), .busy(busy), .tx_start(tx_start),
        .tx_dest_addr(tx_dest_addr), .tx_src_addr(tx_src_addr), .tx_eth_type(tx_eth_type),
        .tx_data(tx_data), .tx_done(tx_done)
    );

    // Timeline model: a frame is described by its grant edge; outcome and gap are cycle arithmetic.
    typedef struct {
        int           cyc;
        bit           valid;
        bit           pend;
        int           g;
        int           free;
        int           busy_until;
        int           last;
        int           gid;
        logic [47:0]  dest;
        logic [47:0]  src;
        logic [15:0]  etype;
        logic [31:0]  data;
        logic [N-1:0] ack;
        logic [N-1:0] err;
        bit           start;
        bit           busy;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur);
        model_t nx;
        int win;
        nx = cur;
        nx.cyc = cur.cyc + 1;
        nx.ack = '0;
        nx.err = '0;
        nx.start = 1'b0;
        win = -1;
        if (!rst_n) begin
            nx.valid = 1'b1;
            nx.pend = 1'b0;
            nx.free = nx.cyc + 1;
            nx.busy_until = 0;
            nx.last = N - 1;
            nx.gid = 0;
            nx.dest = '0;
            nx.src = '0;
            nx.etype = '0;
            nx.data = '0;
        end else if (cur.pend) begin
            if (nx.cyc >= cur.g + 2 && tx_done) nx.ack[cur.gid] = 1'b1;
            else if (nx.cyc == cur.g + TO + 1) nx.err[cur.gid] = 1'b1;
            if ((nx.ack | nx.err) != '0) begin
                nx.pend = 1'b0;
                nx.busy_until = nx.cyc + IFG;
                nx.free = nx.cyc + IFG + 1;
            end
        end else if (nx.cyc >= cur.free && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && req[(cur.last + k) % N]) win = (cur.last + k) % N;
            end
            nx.pend = 1'b1;
            nx.g = nx.cyc;
            nx.start = 1'b1;
            nx.last = win;
            nx.gid = win;
            nx.dest = req_dest_addr[48*win +: 48];
            nx.src = src_addr;
            nx.etype = req_eth_type[16*win +: 16];
            nx.data = req_data[32*win +: 32];
        end
        nx.busy = nx.pend || (nx.cyc < nx.busy_until);
        return nx;
    endfunction

    always @(posedge clk) m <= model_step(m);

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no = 0;
    bit rand_mode = 1'b0;
    int done_delay = 0;
    bit tx_armed = 1'b0;
    int tx_left = 0;
    int rst_left = 0;
    int ack_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [47:0] d, input logic [15:0] t, input logic [31:0] x);
        req_dest_addr[48*i +: 48] = d;
        req_eth_type[16*i +: 16] = t;
        req_data[32*i +: 32] = x;
    endtask

    // One clock: compare at negedge, then play transmitter and (optionally) random requesters.
    task automatic tick();
        int r;
        int d;
        logic [63:0] r64;
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        if (m.valid) begin
            chk("ack", 64'(ack), 64'(m.ack));
            chk("err", 64'(err), 64'(m.err));
            chk("busy", 64'(busy), 64'(m.busy));
            chk("tx_start", 64'(tx_start), 64'(m.start));
            chk("grant_id", 64'(grant_id), 64'(m.gid));
            chk("tx_dest_addr", 64'(tx_dest_addr), 64'(m.dest));
            chk("tx_src_addr", 64'(tx_src_addr), 64'(m.src));
            chk("tx_eth_type", 64'(tx_eth_type), 64'(m.etype));
            chk("tx_data", 64'(tx_data), 64'(m.data));
        end
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(ack[i]);
        tx_done = 1'b0;
        if (tx_armed) begin
            tx_left--;
            if (tx_left <= 0) begin
                tx_done = 1'b1;
                tx_armed = 1'b0;
            end
        end
        if (tx_start) begin
            d = done_delay;
            if (rand_mode) begin
                r = int'($urandom_range(0, 99));
                if (r < 60) d = int'($urandom_range(1, 30));
                else if (r < 72) d = int'($urandom_range(60, 70));
                else if (r < 84) d = TO;
                else if (r < 94) d = int'($urandom_range(31, 59));
                else d = 0;
            end
            tx_armed = (d > 0);
            tx_left = d;
        end
        if (rand_mode) begin
            if (!tx_done && $urandom_range(0, 39) == 0) tx_done = 1'b1;
            if ($urandom_range(0, 19) == 0) src_addr = 48'({$urandom(), $urandom()});
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ((ack[i] || err[i]) && $urandom_range(0, 7) != 0) req[i] = 1'b0;
                    else if ($urandom_range(0, 9) == 0) req_data[32*i +: 32] = $urandom();
                end else if ($urandom_range(0, 5) == 0) begin
                    r64 = {$urandom(), $urandom()};
                    set_fields(i, r64[47:0], 16'($urandom()), $urandom());
                    req[i] = 1'b1;
                end
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                rst_left = int'($urandom_range(1, 3));
            end
        end
    endtask

    function automatic bit hit(input int w);
        case (w)
            W_START: return tx_start;
            W_ACK:   return |ack;
            W_ANY:   return (|ack) || (|err);
            W_IDLE:  return !busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int w, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!hit(w) && n < max);
        chk({name, "_seen"}, 64'(hit(w)), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        req = '0;
        tx_armed = 1'b0;
        done_delay = 0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int gap;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;

        // Reset state and test 1: single frame, field latching, latencies.
        do_reset(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        src_addr = 48'h0A0B0C0D0E0F;
        set_fields(0, 48'h001122334455, 16'h0800, 32'hDEADBEEF);
        done_delay = 20;
        req = 4'b0001;
        wait_sig("t1_start", W_START, 10, n);
        chk("t1_start_latency", 64'(n), 64'd1);
        chk("t1_dest", 64'(tx_dest_addr), 64'h001122334455);
        chk("t1_src", 64'(tx_src_addr), 64'h0A0B0C0D0E0F);
        chk("t1_type", 64'(tx_eth_type), 64'h0800);
        chk("t1_data", 64'(tx_data), 64'hDEADBEEF);
        wait_sig("t1_ack", W_ANY, 100, n);
        chk("t1_ack_latency", 64'(n), 64'd21);
        chk("t1_ack_vec", 64'(ack), 64'h1);
        req = '0;
        wait_sig("t1_idle", W_IDLE, 50, n);
        chk("t1_busy_low_after", 64'(n), 64'd12);

        // Test 6: field change one cycle after grant does not reach tx_data.
        req = 4'b0001;
        wait_sig("t6_start", W_START, 10, n);
        chk("t6_start_latency", 64'(n), 64'd1);
        tick();
        req_data[31:0] = 32'h12345678;
        wait_sig("t6_ack", W_ACK, 100, n);
        chk("t6_ack_latency", 64'(n), 64'd20);
        chk("t6_data_at_ack", 64'(tx_data), 64'hDEADBEEF);
        req = '0;
        wait_sig("t6_idle", W_IDLE, 50, n);

        // Test 2: two requesters from reset, order and gap.
        do_reset(2);
        done_delay = 8;
        set_fields(1, 48'h111111111111, 16'h86DD, 32'h11110001);
        set_fields(2, 48'h222222222222, 16'h0806, 32'h22220002);
        req = 4'b0110;
        wait_sig("t2_start1", W_START, 10, n);
        chk("t2_gid1", 64'(grant_id), 64'd1);
        wait_sig("t2_ack1", W_ACK, 100, n);
        chk("t2_ack1_vec", 64'(ack), 64'h2);
        req[1] = 1'b0;
        wait_sig("t2_start2", W_START, 100, n);
        gap = n + 1;
        chk("t2_gap_ge_14", 64'(gap >= 14), 64'd1);
        chk("t2_gid2", 64'(grant_id), 64'd2);
        chk("t2_dest2", 64'(tx_dest_addr), 64'h222222222222);
        wait_sig("t2_ack2", W_ACK, 100, n);
        chk("t2_ack2_vec", 64'(ack), 64'h4);
        req[2] = 1'b0;
        wait_sig("t2_idle", W_IDLE, 50, n);

        // Test 3: all four held, each dropped on its ack.
        do_reset(2);
        done_delay = 5;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_sig("t3_start", W_START, 100, n);
            chk("t3_order", 64'(grant_id), 64'(k));
            wait_sig("t3_ack", W_ACK, 100, n);
            chk("t3_ack_vec", 64'(ack), 64'(1 << k));
            req[k] = 1'b0;
        end
        wait_sig("t3_idle", W_IDLE, 50, n);
        for (int i = 0; i < N; i++) chk("t3_ack_once", 64'(ack_cnt[i]), 64'd1);

        // Test 4: timeout, then a completion landing exactly on the timeout cycle.
        do_reset(2);
        done_delay = 0;
        req = 4'b1000;
        wait_sig("t4_start", W_START, 10, n);
        chk("t4_gid", 64'(grant_id), 64'd3);
        wait_sig("t4_err", W_ANY, 100, n);
        chk("t4_err_latency", 64'(n), 64'd65);
        chk("t4_err_vec", 64'(err), 64'h8);
        chk("t4_no_ack", 64'(ack), 64'h0);
        req = '0;
        wait_sig("t4_idle", W_IDLE, 50, n);
        chk("t4_busy_low_after", 64'(n), 64'd12);
        done_delay = TO;
        req = 4'b0001;
        wait_sig("t4b_start", W_START, 10, n);
        wait_sig("t4b_end", W_ANY, 100, n);
        chk("t4b_latency", 64'(n), 64'd65);
        chk("t4b_ack_wins", 64'(ack), 64'h1);
        chk("t4b_no_err", 64'(err), 64'h0);
        req = '0;
        wait_sig("t4b_idle", W_IDLE, 50, n);

        // Test 5: reset during WAIT_DONE aborts silently.
        do_reset(2);
        set_fields(0, 48'hAABBCCDDEEFF, 16'h88B5, 32'hCAFEF00D);
        req = 4'b0001;
        wait_sig("t5_start", W_START, 10, n);
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            chk("t5_rst_busy", 64'(busy), 64'd0);
            chk("t5_rst_dest", 64'(tx_dest_addr), 64'd0);
            chk("t5_rst_ackerr", 64'(ack | err), 64'd0);
        end
        rst_n = 1'b1;
        done_delay = 5;
        wait_sig("t5_start2", W_START, 10, n);
        chk("t5_gid", 64'(grant_id), 64'd0);
        chk("t5_dest", 64'(tx_dest_addr), 64'hAABBCCDDEEFF);
        wait_sig("t5_end", W_ANY, 100, n);
        chk("t5_ack_vec", 64'(ack), 64'h1);
        req = '0;
        wait_sig("t5_idle", W_IDLE, 50, n);

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        repeat (4000) tick();
        rand_mode = 1'b0;
        rst_n = 1'b1;
        req = '0;
        done_delay = 3;
        wait_sig("final_idle", W_IDLE, 200, n);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
